seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_pkg.sv | 26 ++
 rtl/seg_scan_decode.sv | 22 ++
 rtl/seg_scan_ctrl.sv | 176 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_pkg
// Shared definitions for the 7-segment scan controller:
//   - scan_state_e : scan FSM states (IDLE, BLANK, SHOW)
//   - SEG_OFF      : active-low "all segments dark" pattern (dp included)
//   - SEG_CODE     : hex value -> active-low segment code, bits [6:0] = a..g
// -----------------------------------------------------------------------------
package seg_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } scan_state_e;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   // Index is the 4-bit value; a 0 bit lights the segment.
   localparam logic [6:0] SEG_CODE [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

endpackage : seg_scan_pkg

// File: rtl/seg_scan_decode.sv
// -----------------------------------------------------------------------------
// seg_scan_decode
// Combinational hex + decimal-point to active-low segment decoder.
// Ports:
//   value_i [3:0] : hex digit 0..F
//   dp_i          : decimal point, 1 = lit
//   seg_o   [7:0] : active-low segments, [7]=dp, [6:0]=a..g
// -----------------------------------------------------------------------------
import seg_scan_pkg::*;

module seg_scan_decode (
   input  logic [3:0] value_i,
   input  logic       dp_i,
   output logic [7:0] seg_o
);

   // Table lookup; dp is inverted onto the active-low bus.
   always_comb begin
      seg_o = {~dp_i, SEG_CODE[value_i]};
   end

endmodule : seg_scan_decode

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for common-anode 7-segment digits sharing
// one segment bus. Stores a hex value and dp flag per digit and visits digits
// in turn: BLANK_CYCLES with all anodes off, then SHOW_CYCLES with one anode
// on. Segments are snapshotted at the BLANK->SHOW edge.
// Optional build macro SEG_SCAN_LZB_EN enables leading-zero blanking.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   enable             : 1 = scanning, 0 = display dark (IDLE)
//   wr_en/wr_addr      : single-cycle write strobe and digit index (0 = right)
//   wr_data/wr_dp      : hex value and decimal point for the written digit
//   seg [7:0]          : registered active-low segments, [7]=dp, [6:0]=a..g
//   an [NUM_DIGITS-1:0]: registered active-low anodes, one-hot-low or all 1
//   frame_tick         : one-cycle pulse when the digit index wraps to 0
// -----------------------------------------------------------------------------
import seg_scan_pkg::*;

module seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int SHOW_CYCLES  = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          wr_en,
   input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
   input  logic [3:0]                    wr_data,
   input  logic                          wr_dp,
   output logic [7:0]                    seg,
   output logic [NUM_DIGITS-1:0]         an,
   output logic                          frame_tick
);

   localparam int IW      = $clog2(NUM_DIGITS);
   localparam int CNT_MAX = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0]         SHOW_LAST  = CW'(SHOW_CYCLES - 1);
   localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);

   logic [3:0]            digit_q [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] dp_q;

   scan_state_e           state_q;
   logic [IW-1:0]         idx_q;
   logic [CW-1:0]         cnt_q;
   logic [7:0]            seg_q;
   logic [NUM_DIGITS-1:0] an_q;
   logic                  frame_tick_q;

   logic [7:0]            dec_seg_s;
   logic [7:0]            seg_d;

   // Digit storage; out-of-range addresses (non power-of-two banks) are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_q[i] <= 4'd0;
         end
         dp_q <= '0;
      end else if (wr_en && (32'(wr_addr) < NUM_DIGITS)) begin
         digit_q[wr_addr] <= wr_data;
         dp_q[wr_addr]    <= wr_dp;
      end else begin
         dp_q <= dp_q;
      end
   end

   // One decoder shared by all digits, fed by the digit about to be latched.
   seg_scan_decode u_decode (
      .value_i (digit_q[idx_q]),
      .dp_i    (dp_q[idx_q]),
      .seg_o   (dec_seg_s)
   );

`ifdef SEG_SCAN_LZB_EN
   logic [NUM_DIGITS-1:0] lz_blank_s;

   // A digit is blanked when it and every digit above it are a plain zero.
   always_comb begin
      logic above_zero;
      above_zero = 1'b1;
      lz_blank_s = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         above_zero    = above_zero && (digit_q[i] == 4'd0) && !dp_q[i];
         lz_blank_s[i] = above_zero;
      end
   end

   // Segment value to snapshot at the BLANK->SHOW edge.
   always_comb begin
      if (lz_blank_s[idx_q]) begin
         seg_d = SEG_OFF;
      end else begin
         seg_d = dec_seg_s;
      end
   end
`else
   // Segment value to snapshot at the BLANK->SHOW edge.
   always_comb begin
      seg_d = dec_seg_s;
   end
`endif

   // Scan FSM with registered segment, anode and frame-tick outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         cnt_q        <= '0;
         seg_q        <= SEG_OFF;
         an_q         <= '1;
         frame_tick_q <= 1'b0;
      end else if (!enable) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         cnt_q        <= '0;
         seg_q        <= SEG_OFF;
         an_q         <= '1;
         frame_tick_q <= 1'b0;
      end else begin
         frame_tick_q <= 1'b0;
         case (state_q)
            IDLE: begin
               state_q <= BLANK;
               idx_q   <= '0;
               cnt_q   <= '0;
               seg_q   <= SEG_OFF;
               an_q    <= '1;
            end
            BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  cnt_q   <= '0;
                  seg_q   <= seg_d;
                  an_q    <= ~(AN_ONE << idx_q);
                  state_q <= SHOW;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
                  an_q  <= '1;
               end
            end
            SHOW: begin
               if (cnt_q == SHOW_LAST) begin
                  cnt_q   <= '0;
                  an_q    <= '1;
                  state_q <= BLANK;
                  if (idx_q == IDX_LAST) begin
                     idx_q        <= '0;
                     frame_tick_q <= 1'b1;
                  end else begin
                     idx_q <= idx_q + IW'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               idx_q   <= '0;
               cnt_q   <= '0;
               seg_q   <= SEG_OFF;
               an_q    <= '1;
            end
         endcase
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign frame_tick = frame_tick_q;

endmodule : seg_scan_ctrl

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Randomised bench for seg_scan_ctrl. Two instances (4 digits and 3 digits,
// SHOW_CYCLES=8, BLANK_CYCLES=2) share all inputs; the 3-digit one sees
// wr_addr=3 as an out-of-range write. Expected outputs come from a timeline
// model: the number of enabled edges since the scan started fixes which digit
// is lit and when frames wrap.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

   localparam int SHOW  = 8;
   localparam int BLANK = 2;
   localparam int SLOT  = SHOW + BLANK;
`ifdef SEG_SCAN_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       enable  = 1'b0;
   logic       wr_en   = 1'b0;
   logic [1:0] wr_addr = 2'd0;
   logic [3:0] wr_data = 4'd0;
   logic       wr_dp   = 1'b0;

   logic [7:0] seg4, seg3;
   logic [3:0] an4;
   logic [2:0] an3;
   logic       ft4, ft3;

   int n_checks = 0;
   int n_fail   = 0;

   logic [6:0] code_tab [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   // Model state, index 0 = 4-digit instance, 1 = 3-digit instance.
   logic [3:0] mdig [2][8];
   logic       mdp  [2][8];
   logic [7:0] mseg [2];
   logic [7:0] ean  [2];
   logic       eft  [2];
   int         k;     // enabled edges since leaving IDLE; 0 = idle

   always #5 clk = ~clk;

   seg_scan_ctrl #(.NUM_DIGITS(4), .SHOW_CYCLES(SHOW), .BLANK_CYCLES(BLANK)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_dp(wr_dp), .seg(seg4), .an(an4), .frame_tick(ft4)
   );

   seg_scan_ctrl #(.NUM_DIGITS(3), .SHOW_CYCLES(SHOW), .BLANK_CYCLES(BLANK)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_dp(wr_dp), .seg(seg3), .an(an3), .frame_tick(ft3)
   );

   function automatic int nd(input int b);
      return (b == 0) ? 4 : 3;
   endfunction

   function automatic logic lz(input int b, input int i);
      logic r;
      r = (i != 0);
      for (int j = i; j < nd(b); j++) begin
         if (mdig[b][j] != 4'd0 || mdp[b][j]) r = 1'b0;
      end
      return r && LZB;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clear_model();
      k = 0;
      for (int b = 0; b < 2; b++) begin
         mseg[b] = 8'hFF;
         for (int i = 0; i < 8; i++) begin
            mdig[b][i] = 4'd0;
            mdp[b][i]  = 1'b0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_an4"},  32'(an4),  32'(ean[0][3:0]));
      chk({tag, "_seg4"}, 32'(seg4), 32'(mseg[0]));
      chk({tag, "_ft4"},  32'(ft4),  32'(eft[0]));
      chk({tag, "_an3"},  32'(an3),  32'(ean[1][2:0]));
      chk({tag, "_seg3"}, 32'(seg3), 32'(mseg[1]));
      chk({tag, "_ft3"},  32'(ft3),  32'(eft[1]));
   endtask

   // Advance one clock edge, update the model, then compare just after the edge.
   task automatic step();
      int o, slot, d;
      @(posedge clk);
      if (!enable) k = 0;
      else k++;
      for (int b = 0; b < 2; b++) begin
         ean[b] = 8'hFF;
         eft[b] = 1'b0;
         if (k == 0) begin
            mseg[b] = 8'hFF;
         end else begin
            o    = (k - 1) % SLOT;
            slot = (k - 1) / SLOT;
            d    = slot % nd(b);
            if (o == BLANK)
               mseg[b] = lz(b, d) ? 8'hFF : {~mdp[b][d], code_tab[mdig[b][d]]};
            if (o >= BLANK) ean[b][d] = 1'b0;
            eft[b] = (k > 1) && (o == 0) && (d == 0);
         end
         if (wr_en && (int'(wr_addr) < nd(b))) begin
            mdig[b][wr_addr] = wr_data;
            mdp[b][wr_addr]  = wr_dp;
         end
      end
      #1;
      check_all("scan");
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      clear_model();
      for (int b = 0; b < 2; b++) begin
         ean[b] = 8'hFF;
         eft[b] = 1'b0;
      end
      check_all("async_rst");
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bit did_rst;
      did_rst = 1'b0;
      clear_model();
      for (int b = 0; b < 2; b++) begin
         ean[b] = 8'hFF;
         eft[b] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Load 1,2,3,4 while dark, then scan; digit0 gets A.dp mid-show.
      for (int i = 0; i < 4; i++) begin
         wr_en   = 1'b1;
         wr_addr = 2'(i);
         wr_data = 4'(i + 1);
         wr_dp   = 1'b0;
         step();
      end
      wr_en  = 1'b0;
      enable = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (i == 5) begin
            wr_en   = 1'b1;
            wr_addr = 2'd0;
            wr_data = 4'hA;
            wr_dp   = 1'b1;
         end else begin
            wr_en = 1'b0;
         end
         step();
      end

      // Random writes (zero-heavy), occasional enable drops and async resets.
      for (int c = 0; c < 3000; c++) begin
         wr_en   = ($urandom_range(0, 3) == 0);
         wr_addr = 2'($urandom_range(0, 3));
         wr_data = ($urandom_range(0, 4) < 2) ? 4'd0 : 4'($urandom);
         wr_dp   = ($urandom_range(0, 4) == 0);
         if (!enable) enable = ($urandom_range(0, 2) == 0);
         else if ($urandom_range(0, 299) == 0 || c % 700 == 350) enable = 1'b0;
         if ((!did_rst && c > 1500 && ft4) || c == 2600) begin
            did_rst = 1'b1;
            do_reset();
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_seg_scan_ctrl
